// File: rtl/pe_array_seq.sv
// Tile sequencer for pe_array_8x8: streams A/B words from the tile buffers, runs compute, drains C into the result buffer.
// Optional watchdog on the wait states is enabled by defining PE_SEQ_TIMEOUT_EN.
module pe_array_seq #(
  parameter int SIDE           = 8,
  parameter int ELEM_BITS      = 8,
  parameter int ACC_BITS       = 32,
  parameter int K_CYCLES       = 8,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_a_base,
  input  logic [ADDR_W-1:0]   cmd_b_base,
  input  logic [ADDR_W-1:0]   cmd_c_base,
  output logic                a_rd_en,
  output logic [ADDR_W-1:0]   a_rd_addr,
  input  logic [31:0]         a_rd_data,
  output logic                b_rd_en,
  output logic [ADDR_W-1:0]   b_rd_addr,
  input  logic [31:0]         b_rd_data,
  output logic                arr_a_ld_start,
  output logic                arr_b_ld_start,
  output logic                arr_a_ld_valid,
  output logic                arr_b_ld_valid,
  output logic [31:0]         arr_a_ld_data,
  output logic [31:0]         arr_b_ld_data,
  input  logic                arr_ld_done,
  output logic                arr_start,
  output logic                arr_acc_clr,
  input  logic                arr_done,
  output logic                arr_c_drain_req,
  input  logic                arr_c_valid,
  input  logic [ACC_BITS-1:0] arr_c_data,
  input  logic                arr_c_last,
  output logic                c_wr_en,
  output logic [ADDR_W-1:0]   c_wr_addr,
  output logic [ACC_BITS-1:0] c_wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int NW = SIDE * K_CYCLES / 4;
  localparam int NC = SIDE * SIDE;
  localparam int LW = $clog2(NW + 1);
  localparam int CW = $clog2(NC + 1);

  if (((SIDE * K_CYCLES) % 4 != 0) || (ELEM_BITS * 4 != 32) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_err
    $error("pe_array_seq: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, LD, LD_WAIT, RUN, WAIT_DONE, DRAIN_REQ, DRAIN, FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] a_base, b_base, c_base;
  logic [LW-1:0]     ld_cnt;
  logic [CW-1:0]     c_idx;
  logic              ld_vld;
  logic              err_set;
  logic              timeout;

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;
  logic           wait_st;

  assign wait_st = (state == LD_WAIT) || (state == WAIT_DONE) || (state == DRAIN);
  // a C beat in the cycle the limit is hit still counts as progress
  assign timeout = wait_st && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) &&
                   !((state == DRAIN) && arr_c_valid);

  always_ff @(posedge clk) begin
    if (rst || (state != state_nxt) || ((state == DRAIN) && arr_c_valid)) wd_cnt <= '0;
    else if (wait_st)                                                     wd_cnt <= wd_cnt + WDW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    err_set         = 1'b0;
    arr_c_drain_req = 1'b0;
    case (state)
      IDLE:      if (cmd_valid) state_nxt = LD;
      LD:        if (ld_cnt == LW'(NW - 1)) state_nxt = LD_WAIT;
      LD_WAIT:   if (arr_ld_done) state_nxt = RUN;
      RUN:       state_nxt = WAIT_DONE;
      WAIT_DONE: if (arr_done) state_nxt = DRAIN_REQ;
      DRAIN_REQ: begin
        arr_c_drain_req = 1'b1;
        state_nxt       = DRAIN;
      end
      DRAIN: begin
        if (arr_c_valid) begin
          if (arr_c_last) begin
            state_nxt = FIN;
            err_set   = (c_idx != CW'(NC - 1));
          end else if (c_idx == CW'(NC - 1)) begin
            state_nxt = FIN;
            err_set   = 1'b1;
          end
        end
      end
      FIN:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (timeout) begin
      err_set   = 1'b1;
      state_nxt = FIN;
      if (state == WAIT_DONE) arr_c_drain_req = 1'b1;
    end
  end

  // gating cmd_ready with rst keeps every output low while reset is held
  assign cmd_ready      = (state == IDLE) && !rst;
  assign busy           = (state != IDLE);
  assign done           = (state == FIN);
  assign a_rd_en        = (state == LD);
  assign b_rd_en        = (state == LD);
  assign a_rd_addr      = a_rd_en ? a_base + ADDR_W'(ld_cnt) : '0;
  assign b_rd_addr      = b_rd_en ? b_base + ADDR_W'(ld_cnt) : '0;
  assign arr_a_ld_start = (state == LD) && (ld_cnt == '0);
  assign arr_b_ld_start = arr_a_ld_start;
  assign arr_a_ld_valid = ld_vld;
  assign arr_b_ld_valid = ld_vld;
  assign arr_a_ld_data  = ld_vld ? a_rd_data : '0;
  assign arr_b_ld_data  = ld_vld ? b_rd_data : '0;
  assign arr_start      = (state == RUN);
  assign arr_acc_clr    = arr_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_base    <= '0;
      b_base    <= '0;
      c_base    <= '0;
      ld_cnt    <= '0;
      ld_vld    <= 1'b0;
      c_idx     <= '0;
      c_wr_en   <= 1'b0;
      c_wr_addr <= '0;
      c_wr_data <= '0;
      err       <= 1'b0;
    end else begin
      state   <= state_nxt;
      ld_vld  <= (state == LD);
      ld_cnt  <= (state == LD) ? ld_cnt + LW'(1) : '0;
      c_wr_en <= 1'b0;
      if ((state == IDLE) && cmd_valid) begin
        a_base <= cmd_a_base;
        b_base <= cmd_b_base;
        c_base <= cmd_c_base;
        err    <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
      if (state != DRAIN) begin
        c_idx <= '0;
      end else if (arr_c_valid) begin
        c_wr_en   <= 1'b1;
        c_wr_addr <= c_base + ADDR_W'(c_idx);
        c_wr_data <= arr_c_data;
        c_idx     <= c_idx + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq: buffer models, inline array model, scoreboards for load beats and C writes.
module tb_pe_array_seq;
  localparam int SIDE = 8, K = 8, AW = 16, NW = SIDE * K / 4, NC = SIDE * SIDE;
  localparam logic [15:0] A_BASE = 16'h10, B_BASE = 16'h40, C_BASE = 16'h100;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_a_base = '0, cmd_b_base = '0, cmd_c_base = '0;
  logic a_rd_en, b_rd_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [31:0] a_rd_data = '0, b_rd_data = '0;
  logic arr_a_ld_start, arr_b_ld_start, arr_a_ld_valid, arr_b_ld_valid;
  logic [31:0] arr_a_ld_data, arr_b_ld_data;
  logic arr_ld_done = 1'b0, arr_start, arr_acc_clr, arr_done = 1'b0, arr_c_drain_req;
  logic arr_c_valid = 1'b0, arr_c_last = 1'b0;
  logic [31:0] arr_c_data = '0;
  logic c_wr_en;
  logic [AW-1:0] c_wr_addr;
  logic [31:0] c_wr_data;
  logic busy, done, err;

  always #5 clk = ~clk;

  pe_array_seq #(.SIDE(SIDE), .ELEM_BITS(8), .ACC_BITS(32), .K_CYCLES(K), .ADDR_W(AW),
                 .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_c_base(cmd_c_base),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .arr_a_ld_start(arr_a_ld_start), .arr_b_ld_start(arr_b_ld_start),
    .arr_a_ld_valid(arr_a_ld_valid), .arr_b_ld_valid(arr_b_ld_valid),
    .arr_a_ld_data(arr_a_ld_data), .arr_b_ld_data(arr_b_ld_data),
    .arr_ld_done(arr_ld_done), .arr_start(arr_start), .arr_acc_clr(arr_acc_clr),
    .arr_done(arr_done), .arr_c_drain_req(arr_c_drain_req), .arr_c_valid(arr_c_valid),
    .arr_c_data(arr_c_data), .arr_c_last(arr_c_last), .c_wr_en(c_wr_en),
    .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data), .busy(busy), .done(done), .err(err)
  );

  logic [31:0] a_mem [256];
  logic [31:0] b_mem [256];
  logic [31:0] a_cap [NW];
  logic [31:0] b_cap [NW];
  logic [31:0] exp_a_q [$];
  logic [31:0] exp_b_q [$];
  wr_t         exp_wr_q [$];
  int n_assert = 0, n_fail = 0;
  int done_cnt = 0, ldv_cnt = 0, drq_cnt = 0;

  // tile buffers: one-cycle read latency
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr[7:0]];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr[7:0]];
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (arr_a_ld_valid) ldv_cnt++;
    if (arr_c_drain_req) drq_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [7:0] byte_of(input logic [31:0] w, input int b);
    return w[8*b +: 8];
  endfunction

  // C[i][j] = sum_k A[i][k]*B[k][j]; A row-major by (i,k), B stored per column j by (j,k)
  function automatic logic [31:0] dot(input int i, input int j, input bit cap);
    int s = 0;
    logic [31:0] wa, wb;
    for (int k = 0; k < K; k++) begin
      int ea = i * K + k, eb = j * K + k;
      wa = cap ? a_cap[ea/4] : a_mem[int'(A_BASE) + ea/4];
      wb = cap ? b_cap[eb/4] : b_mem[int'(B_BASE) + eb/4];
      s += int'(byte_of(wa, ea % 4)) * int'(byte_of(wb, eb % 4));
    end
    return 32'(s);
  endfunction

  task automatic start_cmd();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a_base = A_BASE; cmd_b_base = B_BASE; cmd_c_base = C_BASE;
    chk("cmd_ready_idle", {busy, cmd_ready}, 2'b01);
    for (int w = 0; w < NW; w++) begin
      exp_a_q.push_back(a_mem[int'(A_BASE) + w]);
      exp_b_q.push_back(b_mem[int'(B_BASE) + w]);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ld_start", {arr_a_ld_start, arr_b_ld_start, a_rd_en, b_rd_en, arr_a_ld_valid}, 5'b11110);
    chk("accept_busy_err", {busy, err}, 2'b10);
  endtask

  task automatic load_phase();
    int a_beats = 0, b_beats = 0;
    for (int c = 1; c <= NW + 3; c++) begin
      @(negedge clk);
      if (arr_b_ld_valid) b_beats++;
      if (arr_a_ld_valid) begin
        if (a_beats == 0) chk("first_beat_cycle", c, 1);
        if (exp_a_q.size() == 0 || exp_b_q.size() == 0) chk("ld_sb_empty", 1, 0);
        else begin
          chk("a_ld_data", arr_a_ld_data, exp_a_q.pop_front());
          chk("b_ld_data", arr_b_ld_data, exp_b_q.pop_front());
        end
        if (a_beats < NW) begin
          a_cap[a_beats] = arr_a_ld_data;
          b_cap[a_beats] = arr_b_ld_data;
        end
        a_beats++;
      end
    end
    chk("a_ld_beats", a_beats, NW);
    chk("b_ld_beats", b_beats, NW);
    chk("ld_data_idle", {arr_a_ld_valid, arr_a_ld_data, arr_b_ld_data}, '0);
  endtask

  task automatic compute_phase();
    @(negedge clk); arr_ld_done = 1'b1;
    @(negedge clk); arr_ld_done = 1'b0;
    chk("arr_start", {arr_start, arr_acc_clr}, 2'b11);
    @(negedge clk);
    chk("arr_start_pulse", {arr_start, arr_acc_clr, arr_c_drain_req}, 3'b000);
    repeat (2) @(negedge clk);
    arr_done = 1'b1;
    @(negedge clk); arr_done = 1'b0;
    chk("drain_req", arr_c_drain_req, 1'b1);
  endtask

  task automatic drain_phase(input int last_at, input bit hold_next, input bit exp_err);
    int n = 0, writes = 0, n_send;
    bit seen_done = 0, ready_bad = 0;
    n_send = (last_at < 0) ? NC : last_at + 1;
    for (int cyc = 0; cyc < NC + 20 && !seen_done; cyc++) begin
      @(negedge clk);
      if (c_wr_en) begin
        writes++;
        if (exp_wr_q.size() == 0) chk("wr_sb_empty", 1, 0);
        else begin
          wr_t e = exp_wr_q.pop_front();
          chk("c_wr_addr", c_wr_addr, e.addr);
          chk("c_wr_data", c_wr_data, e.data);
        end
      end
      if (busy && cmd_ready) ready_bad = 1;
      if (done) begin
        seen_done = 1;
        chk("err_at_done", err, exp_err);
      end
      if (hold_next && n == 2) cmd_valid = 1'b1;
      if (n < n_send && !seen_done) begin
        arr_c_valid = 1'b1;
        arr_c_data  = dot(n / SIDE, n % SIDE, 1'b1);
        arr_c_last  = (n == n_send - 1);
        exp_wr_q.push_back('{addr: C_BASE + 16'(n), data: dot(n / SIDE, n % SIDE, 1'b0)});
        n++;
      end else begin
        arr_c_valid = 1'b0; arr_c_last = 1'b0; arr_c_data = '0;
      end
    end
    arr_c_valid = 1'b0; arr_c_last = 1'b0;
    chk("done_seen", seen_done, 1'b1);
    chk("c_writes", writes, n_send);
    chk("wr_sb_left", exp_wr_q.size(), 0);
    if (hold_next) chk("no_accept_busy", ready_bad, 1'b0);
  endtask

  initial begin
    int d0, l0, q0, n;
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = {8'(i * 29 + 5), 8'(i * 71 + 200), 8'(i ^ 8'h5a), 8'(i * 13 + 131)};
      b_mem[i] = {8'(i * 17 + 99), 8'(i * 3 + 250), 8'(i * 53 ^ 8'hc3), 8'(i + 64)};
    end
    repeat (2) @(negedge clk);
    chk("reset_outputs", |{cmd_ready, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_a_ld_start,
        arr_b_ld_start, arr_a_ld_valid, arr_b_ld_valid, arr_a_ld_data, arr_b_ld_data, arr_start,
        arr_acc_clr, arr_c_drain_req, c_wr_en, c_wr_addr, c_wr_data, busy, done, err}, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {cmd_ready, busy, done}, 3'b100);

    // stray array inputs in IDLE
    arr_done = 1'b1; arr_ld_done = 1'b1; arr_c_valid = 1'b1; arr_c_last = 1'b1;
    @(negedge clk);
    arr_done = 1'b0; arr_ld_done = 1'b0; arr_c_valid = 1'b0; arr_c_last = 1'b0;
    @(negedge clk);
    chk("stray_ignored", {busy, c_wr_en, err, cmd_ready}, 4'b0001);

    // full tile
    d0 = done_cnt; l0 = ldv_cnt; q0 = drq_cnt;
    start_cmd(); load_phase(); compute_phase(); drain_phase(-1, 1'b0, 1'b0);
    @(negedge clk);
    chk("tile1_done_once", done_cnt - d0, 1);
    chk("tile1_ldv_cycles", ldv_cnt - l0, NW);
    chk("tile1_drain_once", drq_cnt - q0, 1);
    chk("tile1_idle", {busy, err}, 2'b00);

    // early c_last on beat 10, next command held during drain
    d0 = done_cnt;
    start_cmd(); load_phase(); compute_phase(); drain_phase(10, 1'b1, 1'b1);
    start_cmd();
    chk("tile2_done_once", done_cnt - d0, 1);
    load_phase(); compute_phase(); drain_phase(-1, 1'b0, 1'b0);

    // reset in the middle of the load
    start_cmd();
    repeat (3) @(negedge clk);
    chk("beat3_valid", arr_a_ld_valid, 1'b1);
    rst = 1'b1; d0 = done_cnt;
    @(negedge clk);
    chk("midrst_outputs", |{cmd_ready, a_rd_en, b_rd_en, arr_a_ld_valid, arr_b_ld_valid,
        arr_a_ld_data, arr_b_ld_data, arr_a_ld_start, arr_start, arr_c_drain_req, c_wr_en,
        c_wr_addr, busy, done, err}, 1'b0);
    rst = 1'b0;
    exp_a_q.delete(); exp_b_q.delete();
    repeat (4) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    start_cmd(); load_phase(); compute_phase(); drain_phase(-1, 1'b0, 1'b0);

`ifdef PE_SEQ_TIMEOUT_EN
    // arr_done never arrives
    @(negedge clk);
    q0 = drq_cnt; d0 = done_cnt;
    start_cmd(); load_phase();
    @(negedge clk); arr_ld_done = 1'b1;
    @(negedge clk); arr_ld_done = 1'b0;
    chk("to_arr_start", arr_start, 1'b1);
    n = 0;
    while (!arr_c_drain_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 50);
    @(negedge clk);
    chk("to_done_err", {done, err}, 2'b11);
    repeat (3) @(negedge clk);
    chk("to_drain_once", drq_cnt - q0, 1);
    chk("to_done_once", done_cnt - d0, 1);
    chk("to_idle", {busy, err}, 2'b01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
